// File: rtl/lda_feature_frontend.sv
// Feature front end for the lda classifier: averages a serial per-channel sample stream over
// 2**LOG2_AVG frames into a held DIMS-wide vector. Optional macro BASELINE_SUB_EN adds baseline subtraction.
module lda_feature_frontend #(
  parameter int unsigned DIMS     = 6,
  parameter int unsigned W        = 8,
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [W-1:0]      s_data_i,
  input  logic              s_sof_i,
  input  logic              base_capture_i,
  output logic [DIMS*W-1:0] feat_o,
  output logic              feat_valid_o,
  output logic              sync_err_o
);

  localparam int unsigned ACC_W  = W + LOG2_AVG;
  localparam int unsigned FRAMES = 1 << LOG2_AVG;
  localparam int unsigned CH_W   = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int unsigned FR_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  typedef enum logic {ST_ACCUM = 1'b0, ST_DUMP = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc [DIMS];
  logic [CH_W-1:0]    r_ch_cnt;
  logic [FR_W-1:0]    r_fr_cnt;
  logic               w_hs;
  logic               w_sync_loss;
  logic               w_ch_wrap;
  logic               w_last;
  logic [CH_W-1:0]    w_ch_eff;
  logic [CH_W-1:0]    w_ch_nxt;
  logic [FR_W-1:0]    w_fr_eff;
  logic [FR_W-1:0]    w_fr_nxt;
  logic [W-1:0]       w_avg [DIMS];
  logic [DIMS*W-1:0]  w_feat_nxt;

  assign w_hs = s_valid_i && s_ready_o;

  // A sof on a non-zero channel resynchronises: the sample becomes channel 0 of frame 0.
  always_comb begin
    w_sync_loss = w_hs && s_sof_i && (r_ch_cnt != '0);
    w_ch_eff    = w_sync_loss ? '0 : r_ch_cnt;
    w_fr_eff    = w_sync_loss ? '0 : r_fr_cnt;
    w_ch_wrap   = (w_ch_eff == CH_W'(DIMS - 1));
    w_last      = w_hs && w_ch_wrap && (w_fr_eff == FR_W'(FRAMES - 1));
    w_ch_nxt    = w_ch_wrap ? '0 : w_ch_eff + CH_W'(1);
    w_fr_nxt    = w_ch_wrap ? w_fr_eff + FR_W'(1) : w_fr_eff;
  end

  always_comb begin
    for (int unsigned i = 0; i < DIMS; i++) begin
      w_avg[i] = W'(r_acc[i] >> LOG2_AVG);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_ACCUM;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_last) w_state_nxt = ST_DUMP;
      ST_DUMP:  w_state_nxt = ST_ACCUM;
      default:  w_state_nxt = ST_ACCUM;
    endcase
  end

  // Source must hold its sample through the single dump cycle.
  always_comb begin
    s_ready_o = 1'b1;
    case (r_state)
      ST_DUMP: s_ready_o = 1'b0;
      default: s_ready_o = 1'b1;
    endcase
  end

`ifdef BASELINE_SUB_EN
  logic         r_cap_pend;
  logic [W-1:0] r_base [DIMS];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cap_pend <= 1'b0;
      for (int unsigned i = 0; i < DIMS; i++) r_base[i] <= '0;
    end else if (r_state == ST_DUMP) begin
      r_cap_pend <= base_capture_i;
      if (r_cap_pend) begin
        for (int unsigned i = 0; i < DIMS; i++) r_base[i] <= w_avg[i];
      end
    end else begin
      r_cap_pend <= r_cap_pend | base_capture_i;
    end
  end

  // Capturing dump reports zero; otherwise subtract baseline, saturating at 0.
  always_comb begin
    w_feat_nxt = '0;
    for (int unsigned i = 0; i < DIMS; i++) begin
      if (!r_cap_pend && (w_avg[i] > r_base[i])) begin
        w_feat_nxt[i*W +: W] = w_avg[i] - r_base[i];
      end
    end
  end
`else
  logic w_unused_base_capture;
  assign w_unused_base_capture = base_capture_i;

  always_comb begin
    w_feat_nxt = '0;
    for (int unsigned i = 0; i < DIMS; i++) w_feat_nxt[i*W +: W] = w_avg[i];
  end
`endif

  // Accumulate / dump datapath.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DIMS; i++) r_acc[i] <= '0;
      r_ch_cnt     <= '0;
      r_fr_cnt     <= '0;
      feat_o       <= '0;
      feat_valid_o <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      feat_valid_o <= 1'b0;
      sync_err_o   <= w_sync_loss;
      if (r_state == ST_DUMP) begin
        for (int unsigned i = 0; i < DIMS; i++) r_acc[i] <= '0;
        r_ch_cnt     <= '0;
        r_fr_cnt     <= '0;
        feat_o       <= w_feat_nxt;
        feat_valid_o <= 1'b1;
      end else if (w_hs) begin
        for (int unsigned i = 0; i < DIMS; i++) begin
          r_acc[i] <= (w_sync_loss ? '0 : r_acc[i])
                    + ((CH_W'(i) == w_ch_eff) ? ACC_W'(s_data_i) : '0);
        end
        r_ch_cnt <= w_ch_nxt;
        r_fr_cnt <= w_fr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lda_feature_frontend.sv
// Directed + randomized bench for lda_feature_frontend (DIMS=6, W=8, LOG2_AVG=2).
module tb_lda_feature_frontend;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [7:0]  s_data_i = '0;
  logic        s_sof_i = 1'b0;
  logic        base_capture_i = 1'b0;
  logic [47:0] feat_o;
  logic        feat_valid_o;
  logic        sync_err_o;

  lda_feature_frontend #(.DIMS(6), .W(8), .LOG2_AVG(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .s_sof_i(s_sof_i), .base_capture_i(base_capture_i),
    .feat_o(feat_o), .feat_valid_o(feat_valid_o), .sync_err_o(sync_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int last_waits = 0;
  int n_rdy_low = 0;
  int n_se = 0;
  logic [47:0] fq[$];
  int          fcq[$];

  logic [7:0] win [24];
  int         bl [6];
  bit         cap_pend = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (feat_valid_o) begin
      fq.push_back(feat_o);
      fcq.push_back(cyc);
    end
    if (sync_err_o) n_se++;
    if (!s_ready_o) n_rdy_low++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample, optionally after idle cycles; return one cycle after its handshake.
  task automatic send(input logic [7:0] d, input logic sof, input int gap);
    int  waits;
    bit  hs;
    repeat (gap) begin @(posedge clk_i); #1; end
    s_valid_i = 1'b1; s_data_i = d; s_sof_i = sof;
    waits = 0; hs = 1'b0;
    while (!hs && waits < 50) begin
      @(negedge clk_i);
      hs = s_ready_o;
      if (hs) hs_cyc = cyc;
      @(posedge clk_i); #1;
      if (!hs) waits++;
    end
    s_valid_i = 1'b0; s_sof_i = 1'b0;
    last_waits = waits;
    if (!hs) begin
      vectors++; miscompares++;
      $error("FAIL hs_timeout: observed no handshake expected handshake");
    end
  endtask

  task automatic send_window(input int first, input int gapmax);
    for (int k = first; k < 24; k++) send(win[k], (k % 6) == 0, $urandom_range(0, gapmax));
  endtask

  task automatic pop_feat(output logic [47:0] v, output int c);
    int t = 0;
    while (fq.size() == 0 && t < 20) begin @(posedge clk_i); #1; t++; end
    if (fq.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL feat_timeout: observed no feat_valid expected feat_valid");
      v = 'x; c = -1;
    end else begin
      v = fq.pop_front();
      c = fcq.pop_front();
    end
  endtask

  // Reference: per-channel mean of four frames, then baseline handling.
  function automatic logic [47:0] exp_feat();
    logic [47:0] v;
    int s, a;
    v = '0;
    for (int c = 0; c < 6; c++) begin
      s = 0;
      for (int f = 0; f < 4; f++) s += int'(win[f*6 + c]);
      a = s / 4;
      if (cap_pend) a = 0;
      else          a = (a > bl[c]) ? a - bl[c] : 0;
      v[c*8 +: 8] = 8'(a);
    end
    return v;
  endfunction

  task automatic fill(input int val);
    for (int k = 0; k < 24; k++) win[k] = 8'(val);
  endtask

  initial begin
    logic [47:0] fv, ex, ex_prev;
    int          fc, r0, se0, hs_prev, hs_first;

    for (int c = 0; c < 6; c++) bl[c] = 0;
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // 1: reset state
    check("rst_feat", 64'(feat_o), 64'(0));
    check("rst_fvalid", 64'(feat_valid_o), 64'(0));
    check("rst_syncerr", 64'(sync_err_o), 64'(0));
    check("rst_ready", 64'(s_ready_o), 64'(1));

    // 2: back-to-back frames, value 10*i+f+1
    for (int f = 0; f < 4; f++) for (int i = 0; i < 6; i++) win[f*6 + i] = 8'(10*i + f + 1);
    ex = exp_feat();
    r0 = n_rdy_low;
    send_window(0, 0);
    check("t2_dump_ready", 64'(s_ready_o), 64'(0));
    @(posedge clk_i); #1;
    check("t2_fvalid", 64'(feat_valid_o), 64'(1));
    check("t2_ready_back", 64'(s_ready_o), 64'(1));
    check("t2_feat", 64'(feat_o), 64'(ex));
    @(posedge clk_i); #1;
    check("t2_fvalid_pulse", 64'(feat_valid_o), 64'(0));
    check("t2_ready_low_cycles", 64'(n_rdy_low - r0), 64'(1));
    check("t2_nfeat", 64'(fq.size()), 64'(1));
    pop_feat(fv, fc);
    check("t2_latency", 64'(fc - hs_cyc), 64'(2));

    // 3: all 255 with gaps, then a random window whose first sample is held across the dump
    fill(255);
    ex_prev = exp_feat();
    send_window(0, 3);
    hs_prev = hs_cyc;
    for (int k = 0; k < 24; k++) win[k] = 8'($urandom_range(0, 255));
    ex = exp_feat();
    send(win[0], 1'b1, 0);
    hs_first = hs_cyc;
    check("t3_hold_waits", 64'(last_waits), 64'(1));
    check("t3_hold_accept_cyc", 64'(hs_first - hs_prev), 64'(2));
    pop_feat(fv, fc);
    check("t3_feat255", 64'(fv), 64'(ex_prev));
    check("t3_latency", 64'(fc - hs_prev), 64'(2));
    send_window(1, 2);
    pop_feat(fv, fc);
    check("t3_feat_rand", 64'(fv), 64'(ex));

    // 4: sof on the 4th sample of frame 1 restarts the window
    for (int k = 0; k < 9; k++) send(8'd3, (k % 6) == 0, 0);
    se0 = n_se;
    fill(7);
    ex = exp_feat();
    send(8'd7, 1'b1, 0);
    check("t4_syncerr", 64'(sync_err_o), 64'(1));
    @(posedge clk_i); #1;
    check("t4_syncerr_pulse", 64'(sync_err_o), 64'(0));
    check("t4_no_early_feat", 64'(fq.size()), 64'(0));
    send_window(1, 1);
    check("t4_nsyncerr", 64'(n_se - se0), 64'(1));
    pop_feat(fv, fc);
    check("t4_feat7", 64'(fv), 64'(ex));

    // 5: reset mid-window discards the partial sum
    for (int k = 0; k < 15; k++) send(8'd200, (k % 6) == 0, 0);
    rstn_i = 1'b0;
    #3;
    check("t5_rst_feat", 64'(feat_o), 64'(0));
    check("t5_rst_ready", 64'(s_ready_o), 64'(1));
    @(posedge clk_i); #1 rstn_i = 1'b1;
    fill(9);
    ex = exp_feat();
    send_window(0, 1);
    pop_feat(fv, fc);
    check("t5_feat9", 64'(fv), 64'(ex));

    // 6: baseline handling
`ifdef BASELINE_SUB_EN
    fill(100);
    ex = exp_feat();
    for (int c = 0; c < 6; c++) bl[c] = int'(ex[c*8 +: 8]);
    cap_pend = 1'b1;
    ex = exp_feat();
    base_capture_i = 1'b1;
    @(posedge clk_i); #1 base_capture_i = 1'b0;
    send_window(0, 1);
    pop_feat(fv, fc);
    check("t6_capture_zero", 64'(fv), 64'(ex));
    cap_pend = 1'b0;
    fill(130);
    ex = exp_feat();
    send_window(0, 1);
    pop_feat(fv, fc);
    check("t6_sub130", 64'(fv), 64'(ex));
    fill(50);
    ex = exp_feat();
    send_window(0, 1);
    pop_feat(fv, fc);
    check("t6_sat50", 64'(fv), 64'(ex));
`else
    base_capture_i = 1'b1;
    @(posedge clk_i); #1 base_capture_i = 1'b0;
    fill(130);
    ex = exp_feat();
    send_window(0, 1);
    pop_feat(fv, fc);
    check("t6_plain130", 64'(fv), 64'(ex));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
